// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset PC, opcode encodings, fetch FSM states.
package cpu_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;
  localparam int IMM_W   = 10;

  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] OUT = 3'b100;
  localparam logic [2:0] LDI = 3'b101;
  localparam logic [2:0] BNE = 3'b110;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/branch_target.sv
// Branch target: base + sign-extended IMM_W offset, wrapping modulo 2^ADDR_W.
// Purely combinational; no handshake.
module branch_target #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int IMM_W  = cpu_pkg::IMM_W
) (
  input  logic [ADDR_W-1:0] base_i,
  input  logic [IMM_W-1:0]  offset_i,
  output logic [ADDR_W-1:0] target_o
);

  logic [ADDR_W-1:0] offset_ext;

  assign offset_ext = {{(ADDR_W-IMM_W){offset_i[IMM_W-1]}}, offset_i};
  assign target_o   = base_i + offset_ext;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, registers the ROM word into a one-entry slot; 1-cycle fetch latency.
// Slot holds while out_ready=0; redirect flushes the slot and costs a 1-cycle bubble.
module fetch_stage #(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                INSTR_W  = cpu_pkg::INSTR_W,
  parameter int                IMM_W    = cpu_pkg::IMM_W,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redir_valid,
  input  logic [ADDR_W-1:0]  redir_base,
  input  logic [IMM_W-1:0]   redir_offset,
  input  logic               halt,
  output logic               halted
);
  import cpu_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic               out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]  redir_target;
  logic               accept;
  logic               slot_free;

  branch_target #(
    .ADDR_W (ADDR_W),
    .IMM_W  (IMM_W)
  ) u_branch_target (
    .base_i   (redir_base),
    .offset_i (redir_offset),
    .target_o (redir_target)
  );

  assign accept    = out_valid_q & out_ready;
  assign slot_free = ~out_valid_q | accept;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redir_valid) begin
          pc_d        = redir_target;
          out_valid_d = 1'b0;
        end else if (halt) begin
          // Stop capturing but let decode drain what is already in the slot.
          if (accept) out_valid_d = 1'b0;
          if (slot_free) state_d = HALT;
        end else if (slot_free) begin
          out_instr_d = imem_data;
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
          pc_d        = pc_q + 1'b1;
        end
      end
      HALT: begin
        if (redir_valid) begin
          pc_d        = redir_target;
          out_valid_d = 1'b0;
          state_d     = RUN;
        end else if (!halt) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic, checked by an address-stream scoreboard.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        redir_valid = 1'b0;
  logic [15:0] redir_base = 16'h0000;
  logic [9:0]  redir_offset = 10'h000;
  logic        halt = 1'b0;
  logic        halted;

  int total = 0;
  int bad = 0;
  int accepts = 0;

  // Expected stream of fetch addresses the decode side should see, in order.
  logic [15:0] exp_q[$];
  logic [15:0] exp_base = RESET_PC;
  logic [15:0] e;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .redir_valid  (redir_valid),
    .redir_base   (redir_base),
    .redir_offset (redir_offset),
    .halt         (halt),
    .halted       (halted)
  );

  // Multiply program at 0..7, address-unique filler elsewhere.
  function automatic logic [15:0] rom(input logic [15:0] a);
    case (a)
      16'd0:   return {LDI, 3'd0, 10'd2};
      16'd1:   return {LDI, 3'd1, 10'd3};
      16'd2:   return {LDI, 3'd2, 10'd0};
      16'd3:   return {LDI, 3'd3, 10'd1};
      16'd4:   return {ADD, 3'd2, 10'h001};
      16'd5:   return {SUB, 3'd0, 10'h003};
      16'd6:   return {BNE, 3'd0, 10'h3FE};
      16'd7:   return {OUT, 3'd2, 10'h000};
      default: return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endcase
  endfunction

  assign imem_data = rom(imem_addr);

  function automatic logic [15:0] target(input logic [15:0] base, input logic [9:0] off);
    logic signed [9:0] so;
    int sum;
    so  = off;
    sum = int'(base) + int'(so);
    return 16'(sum);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    while (exp_q.size() < 4) begin
      exp_q.push_back(exp_base);
      exp_base = exp_base + 16'd1;
    end
  endtask

  task automatic redirect(input logic [15:0] base, input logic [9:0] off);
    redir_valid  = 1'b1;
    redir_base   = base;
    redir_offset = off;
    exp_q.delete();
    exp_base = target(base, off);
  endtask

  task automatic wait_pc(input logic [15:0] t, input string nm);
    int n;
    n = 0;
    while (!(out_valid === 1'b1 && out_pc === t) && n < 60) begin
      tick();
      n++;
    end
    chk(nm, {15'd0, out_valid, out_pc}, {15'd0, 1'b1, t});
  endtask

  // Monitor: rule checks on the previous cycle's handshake, scoreboard pops on accept.
  logic        p_rst = 1'b0;
  logic        p_redir = 1'b0;
  logic        p_valid = 1'b0;
  logic        p_ready = 1'b0;
  logic [15:0] p_pc = 16'h0;
  logic [15:0] p_instr = 16'h0;

  always @(negedge clk) begin
    if (p_rst) begin
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_pc", {16'd0, out_pc}, 32'd0);
      chk("rst_instr", {16'd0, out_instr}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_addr", {16'd0, imem_addr}, {16'd0, RESET_PC});
    end else if (p_redir) begin
      chk("flush_bubble", {31'd0, out_valid}, 32'd0);
    end else if (p_valid && !p_ready) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_pc", {16'd0, out_pc}, {16'd0, p_pc});
      chk("stall_instr", {16'd0, out_instr}, {16'd0, p_instr});
    end
    if (halted === 1'b1) chk("halted_empty", {31'd0, out_valid}, 32'd0);
    if (!rst && !redir_valid && out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: accepted pc %h, expected no output", out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", {16'd0, out_pc}, {16'd0, e});
        chk("sb_instr", {16'd0, out_instr}, {16'd0, rom(e)});
        accepts++;
      end
    end
    p_rst   <= rst;
    p_redir <= redir_valid;
    p_valid <= out_valid;
    p_ready <= out_ready;
    p_pc    <= out_pc;
    p_instr <= out_instr;
  end

  initial begin
    int halt_cnt;
    halt_cnt = 0;

    tick();
    tick();
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_addr", {16'd0, imem_addr}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("boot_bubble", {31'd0, out_valid}, 32'd0);
    tick();
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("first_pc", {16'd0, out_pc}, 32'd0);
    chk("first_instr", {16'd0, out_instr}, 32'h0000_A002);

    wait_pc(16'd2, "reach_pc2");
    out_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("hold_pc", {16'd0, out_pc}, 32'd2);
      chk("hold_instr", {16'd0, out_instr}, {16'd0, rom(16'd2)});
      chk("hold_addr", {16'd0, imem_addr}, 32'd3);
    end
    out_ready = 1'b1;
    tick();
    chk("release_pc3", {16'd0, out_pc}, 32'd3);
    tick();
    chk("release_pc4", {16'd0, out_pc}, 32'd4);

    wait_pc(16'd5, "reach_pc5");
    halt = 1'b1;
    tick();
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_drained", {31'd0, out_valid}, 32'd0);
    chk("halt_addr", {16'd0, imem_addr}, 32'd6);
    tick();
    tick();
    chk("halt_frozen", {16'd0, imem_addr}, 32'd6);
    halt = 1'b0;
    tick();
    chk("resume_halted", {31'd0, halted}, 32'd0);
    tick();
    chk("resume_pc", {15'd0, out_valid, out_pc}, {15'd0, 1'b1, 16'd6});

    for (int k = 0; k < 3; k++) begin
      wait_pc(16'd7, "loop_at7");
      redirect(16'd6, 10'h3FE);
      tick();
      redir_valid = 1'b0;
      chk("loop_flush", {31'd0, out_valid}, 32'd0);
      tick();
      chk("loop_target", {15'd0, out_valid, out_pc}, {15'd0, 1'b1, 16'd4});
    end
    wait_pc(16'd7, "fall_through7");

    halt = 1'b1;
    tick();
    chk("halt2_halted", {31'd0, halted}, 32'd1);
    tick();
    redirect(16'h0100, 10'd5);
    halt = 1'b0;
    tick();
    redir_valid = 1'b0;
    chk("halt_redir_exit", {31'd0, halted}, 32'd0);
    chk("halt_redir_addr", {16'd0, imem_addr}, 32'h0105);
    tick();
    chk("halt_redir_pc", {15'd0, out_valid, out_pc}, {15'd0, 1'b1, 16'h0105});

    redirect(16'hFFFF, 10'h000);
    tick();
    redir_valid = 1'b0;
    tick();
    chk("wrap_ffff", {16'd0, out_pc}, 32'h0000_FFFF);
    tick();
    chk("wrap_0000", {15'd0, out_valid, out_pc}, {15'd0, 1'b1, 16'h0000});

    out_ready = 1'b0;
    tick();
    redir_valid = 1'b1;
    redir_base  = 16'h1234;
    rst = 1'b1;
    exp_q.delete();
    exp_base = RESET_PC;
    tick();
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_addr", {16'd0, imem_addr}, {16'd0, RESET_PC});
    rst = 1'b0;
    redir_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("midrst_restart", {15'd0, out_valid, out_pc}, {15'd0, 1'b1, RESET_PC});

    for (int i = 0; i < 2000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (halt_cnt > 0) halt_cnt--;
      else if ($urandom_range(0, 79) == 0) halt_cnt = $urandom_range(1, 6);
      halt = (halt_cnt > 0);
      if ($urandom_range(0, 29) == 0) redirect(16'($urandom), 10'($urandom));
      else redir_valid = 1'b0;
      tick();
    end
    redir_valid = 1'b0;
    halt = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("progress", {31'd0, accepts > 800}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
